// File: rtl/cpu_isa_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path.
// Holds the opcode and funct encodings, the ALU operation codes, the control
// FSM state encoding and the bundle of datapath control strobes.
package cpu_isa_pkg;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_NOP   = 6'b110110;

    // R-type funct field, IR[5:0]
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // ALU operation codes (right-aligned into the ALU control port)
    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_ADD  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_LW, S_BRANCH, S_JUMP
    } state_t;

    // Datapath strobes produced by the FSM (ALU control and ext_zero come
    // from the ALU decoder instead).
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       retire;
        logic       illegal;
        logic       bus_error;
    } ctrl_t;

    // Shifts take their first operand from the shamt field.
    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

endpackage

// File: rtl/cpu_alu_decode.sv
// Combinational ALU decoder for the multicycle control path.
// Ports:
//   opcode, funct  effective IR fields (live in DECODE, latched afterwards)
//   state          current control FSM state
//   alu_control    ALU operation, right-aligned, upper bits zero
//   ext_zero       zero-extend immediate (logical immediates in EXEC_I)
//   legal          opcode, and funct for R-type, is a supported instruction
module cpu_alu_decode
    import cpu_isa_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [3:0]            state,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  ext_zero,
    output logic                  legal
);

    logic [3:0] r_code;
    logic [3:0] i_code;
    logic [3:0] code;
    logic       r_ok;
    logic       i_zero;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        r_code = ALU_ADDU;
        r_ok   = 1'b1;
        case (funct)
            FN_ADD:  r_code = ALU_ADD;
            FN_ADDU: r_code = ALU_ADDU;
            FN_SUB:  r_code = ALU_SUB;
            FN_SUBU: r_code = ALU_SUBU;
            FN_AND:  r_code = ALU_AND;
            FN_OR:   r_code = ALU_OR;
            FN_XOR:  r_code = ALU_XOR;
            FN_SLT:  r_code = ALU_SLT;
            FN_SLTU: r_code = ALU_SLTU;
            FN_SLL:  r_code = ALU_SLL;
            FN_SRL:  r_code = ALU_SRL;
            FN_SRA:  r_code = ALU_SRA;
            default: r_ok   = 1'b0;
        endcase

        i_code = ALU_ADDU;
        i_zero = 1'b0;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: legal  = r_ok;
            OP_ADDI:  i_code = ALU_ADD;
            OP_ADDIU: i_code = ALU_ADDU;
            OP_SLTI:  i_code = ALU_SLT;
            OP_SLTIU: i_code = ALU_SLTU;
            OP_ANDI:  begin i_code = ALU_AND; i_zero = 1'b1; end
            OP_ORI:   begin i_code = ALU_OR;  i_zero = 1'b1; end
            OP_XORI:  begin i_code = ALU_XOR; i_zero = 1'b1; end
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_NOP: ;
            default:  legal  = 1'b0;
        endcase

        code     = ALU_ADDU;
        ext_zero = 1'b0;
        case (state)
            S_DECODE: code = ALU_ADD;     // branch target PC + (imm << 2)
            S_EXEC_R: code = r_code;
            S_EXEC_I: begin code = i_code; ext_zero = i_zero; end
            S_BRANCH: code = ALU_SUB;     // compare A and B via zero flag
            default:  code = ALU_ADDU;
        endcase
        alu_control = ALU_CTRL_W'(code);
    end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Multicycle control FSM for the MIPS-subset CPU.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready and
// aborts memory accesses that stay unanswered for MEM_TIMEOUT cycles.
// Ports:
//   clk, rst                       clock and async active-high reset
//   opcode, funct, mem_ready       IR fields and memory handshake
//   pc_write .. alu_src_b          datapath mux selects and strobes
//   ext_zero, alu_control          immediate extension and ALU operation
//   retire, illegal, bus_error     one-cycle status pulses
module cpu_multicycle_control
    import cpu_isa_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  branch_ne,
    output logic [1:0]            pc_source,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  ext_zero,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  retire,
    output logic                  illegal,
    output logic                  bus_error
);

    state_t                state, next_state;
    ctrl_t                 c, c_out;
    logic [5:0]            op_q, fn_q, op_eff, fn_eff;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  tmo_hit, waiting;
    logic [ALU_CTRL_W-1:0] alu_raw;
    logic                  ext_zero_raw, legal;

    // IR fields are live during DECODE; later states use the copy taken when
    // DECODE is left, so the IR may change underneath without effect.
    assign op_eff  = (state == S_DECODE) ? opcode : op_q;
    assign fn_eff  = (state == S_DECODE) ? funct  : fn_q;
    assign tmo_hit = (tmo_cnt == TMO_W'(MEM_TIMEOUT));
    assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    cpu_alu_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decode (
        .opcode      (op_eff),
        .funct       (fn_eff),
        .state       (state),
        .alu_control (alu_raw),
        .ext_zero    (ext_zero_raw),
        .legal       (legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            tmo_cnt <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state <= next_state;
            if (state == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            // Any state change (or a timeout re-entering FETCH) starts a fresh wait.
            if ((next_state != state) || c.bus_error)
                tmo_cnt <= '0;
            else if (waiting && !mem_ready)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_comb begin
        c          = '0;
        next_state = state;
        unique case (state)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    next_state = S_DECODE;
                end else if (tmo_hit) begin
                    c.mem_read  = 1'b0;
                    c.bus_error = 1'b1;
                end
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                next_state  = S_FETCH;
                if (!legal) begin
                    c.illegal = 1'b1;
                end else begin
                    case (opcode)
                        OP_RTYPE: next_state = S_EXEC_R;
                        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                        OP_SLTI, OP_SLTIU: next_state = S_EXEC_I;
                        OP_LW, OP_SW:      next_state = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:    next_state = S_BRANCH;
                        OP_J, OP_JAL:      next_state = S_JUMP;
                        default:           c.retire   = 1'b1;  // only NOP is left
                    endcase
                end
            end
            S_EXEC_R: begin
                c.alu_src_a = is_shift(fn_q) ? 2'b10 : 2'b01;
                next_state  = S_WB_ALU;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                next_state  = S_WB_ALU;
            end
            S_WB_ALU: begin
                c.reg_write = 1'b1;
                c.reg_dst   = (op_q == OP_RTYPE) ? 2'b01 : 2'b00;
                c.retire    = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                next_state  = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
                if (mem_ready) begin
                    next_state = S_WB_LW;
                end else if (tmo_hit) begin
                    c.mem_read  = 1'b0;
                    c.bus_error = 1'b1;
                    next_state  = S_FETCH;
                end
            end
            S_MEM_WR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
                if (mem_ready) begin
                    c.retire   = 1'b1;
                    next_state = S_FETCH;
                end else if (tmo_hit) begin
                    c.mem_write = 1'b0;
                    c.bus_error = 1'b1;
                    next_state  = S_FETCH;
                end
            end
            S_WB_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
                c.retire     = 1'b1;
                next_state   = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a     = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_ne     = (op_q == OP_BNE);
                c.retire        = 1'b1;
                next_state      = S_FETCH;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.retire    = 1'b1;
                if (op_q == OP_JAL) begin
                    // PC already holds PC+4, so r31 gets the return address.
                    c.reg_write  = 1'b1;
                    c.reg_dst    = 2'b10;
                    c.mem_to_reg = 2'b10;
                end
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // All outputs are held low while reset is asserted.
    assign c_out         = rst ? '0 : c;
    assign alu_control   = rst ? '0 : alu_raw;
    assign ext_zero      = rst ? 1'b0 : ext_zero_raw;
    assign pc_write      = c_out.pc_write;
    assign pc_write_cond = c_out.pc_write_cond;
    assign branch_ne     = c_out.branch_ne;
    assign pc_source     = c_out.pc_source;
    assign i_or_d        = c_out.i_or_d;
    assign mem_read      = c_out.mem_read;
    assign mem_write     = c_out.mem_write;
    assign ir_write      = c_out.ir_write;
    assign reg_dst       = c_out.reg_dst;
    assign mem_to_reg    = c_out.mem_to_reg;
    assign reg_write     = c_out.reg_write;
    assign alu_src_a     = c_out.alu_src_a;
    assign alu_src_b     = c_out.alu_src_b;
    assign retire        = c_out.retire;
    assign illegal       = c_out.illegal;
    assign bus_error     = c_out.bus_error;

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Self-checking bench for cpu_multicycle_control: every cycle's full output
// vector is compared against an instruction-level reference model that
// expands each instruction class into its expected per-cycle control steps.
module tb_cpu_multicycle_control;

    localparam int MEM_TIMEOUT = 15;

    logic       clk, rst, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_write, ext_zero, retire, illegal, bus_error;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic [3:0] alu_control;

    cpu_multicycle_control #(.ALU_CTRL_W(4), .MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .alu_control(alu_control), .retire(retire), .illegal(illegal), .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [3:0] alu_control;
        logic       retire;
        logic       illegal;
        logic       bus_error;
    } outs_t;

    outs_t obs;
    assign obs = {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, ext_zero, alu_control, retire, illegal, bus_error};

    typedef enum logic [3:0] {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_NOP, K_ILL} kind_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        kind_t      kind;
        logic [3:0] alu;
        logic       ez;
        logic       sh;
    } ent_t;

    ent_t isa[$];
    int   errors = 0;
    int   checks = 0;

    // ---------------- reference model: instruction table ----------------
    task automatic load_isa();
        isa.push_back('{6'o00, 6'o40, K_R, 4'b0111, 1'b0, 1'b0}); // ADD
        isa.push_back('{6'o00, 6'o41, K_R, 4'b0001, 1'b0, 1'b0}); // ADDU
        isa.push_back('{6'o00, 6'o42, K_R, 4'b0010, 1'b0, 1'b0}); // SUB
        isa.push_back('{6'o00, 6'o43, K_R, 4'b0011, 1'b0, 1'b0}); // SUBU
        isa.push_back('{6'o00, 6'o44, K_R, 4'b0100, 1'b0, 1'b0}); // AND
        isa.push_back('{6'o00, 6'o45, K_R, 4'b0101, 1'b0, 1'b0}); // OR
        isa.push_back('{6'o00, 6'o46, K_R, 4'b0110, 1'b0, 1'b0}); // XOR
        isa.push_back('{6'o00, 6'o52, K_R, 4'b1010, 1'b0, 1'b0}); // SLT
        isa.push_back('{6'o00, 6'o53, K_R, 4'b1011, 1'b0, 1'b0}); // SLTU
        isa.push_back('{6'o00, 6'o00, K_R, 4'b1110, 1'b0, 1'b1}); // SLL
        isa.push_back('{6'o00, 6'o02, K_R, 4'b1101, 1'b0, 1'b1}); // SRL
        isa.push_back('{6'o00, 6'o03, K_R, 4'b1100, 1'b0, 1'b1}); // SRA
        isa.push_back('{6'o10, 6'o00, K_I, 4'b0111, 1'b0, 1'b0}); // ADDI
        isa.push_back('{6'o11, 6'o00, K_I, 4'b0001, 1'b0, 1'b0}); // ADDIU
        isa.push_back('{6'o12, 6'o00, K_I, 4'b1010, 1'b0, 1'b0}); // SLTI
        isa.push_back('{6'o13, 6'o00, K_I, 4'b1011, 1'b0, 1'b0}); // SLTIU
        isa.push_back('{6'o14, 6'o00, K_I, 4'b0100, 1'b1, 1'b0}); // ANDI
        isa.push_back('{6'o15, 6'o00, K_I, 4'b0101, 1'b1, 1'b0}); // ORI
        isa.push_back('{6'o16, 6'o00, K_I, 4'b0110, 1'b1, 1'b0}); // XORI
        isa.push_back('{6'o43, 6'o00, K_LW, 4'b0000, 1'b0, 1'b0});
        isa.push_back('{6'o53, 6'o00, K_SW, 4'b0000, 1'b0, 1'b0});
        isa.push_back('{6'o04, 6'o00, K_BEQ, 4'b0000, 1'b0, 1'b0});
        isa.push_back('{6'o05, 6'o00, K_BNE, 4'b0000, 1'b0, 1'b0});
        isa.push_back('{6'o02, 6'o00, K_J, 4'b0000, 1'b0, 1'b0});
        isa.push_back('{6'o03, 6'o00, K_JAL, 4'b0000, 1'b0, 1'b0});
        isa.push_back('{6'o66, 6'o00, K_NOP, 4'b0000, 1'b0, 1'b0});
    endtask

    // Anything not in the table is illegal; funct only matters for R-type.
    function automatic ent_t classify(input logic [5:0] op, input logic [5:0] fn);
        ent_t r;
        r = '{op: op, fn: fn, kind: K_ILL, alu: 4'b0000, ez: 1'b0, sh: 1'b0};
        foreach (isa[i])
            if (isa[i].op == op && (op != 6'o00 || isa[i].fn == fn)) r = isa[i];
        return r;
    endfunction

    // ---------------- reference model: expected cycle outputs ----------------
    function automatic outs_t base();
        outs_t e;
        e = '0;
        e.alu_control = 4'b0001;
        return e;
    endfunction

    function automatic outs_t o_fetch(input bit done);
        outs_t e = base();
        e.mem_read = 1'b1; e.alu_src_b = 2'b01;
        if (done) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
        return e;
    endfunction

    function automatic outs_t o_fetch_tmo();
        outs_t e = base();
        e.alu_src_b = 2'b01; e.bus_error = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_decode(input kind_t k);
        outs_t e = base();
        e.alu_src_b = 2'b11; e.alu_control = 4'b0111;
        e.retire  = (k == K_NOP);
        e.illegal = (k == K_ILL);
        return e;
    endfunction

    function automatic outs_t o_exec(input ent_t inf);
        outs_t e = base();
        e.alu_control = inf.alu;
        if (inf.kind == K_R) begin
            e.alu_src_a = inf.sh ? 2'b10 : 2'b01;
        end else begin
            e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.ext_zero = inf.ez;
        end
        return e;
    endfunction

    function automatic outs_t o_wb_alu(input bit is_r);
        outs_t e = base();
        e.reg_write = 1'b1; e.retire = 1'b1; e.reg_dst = is_r ? 2'b01 : 2'b00;
        return e;
    endfunction

    function automatic outs_t o_mem_addr();
        outs_t e = base();
        e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
        return e;
    endfunction

    function automatic outs_t o_mem(input bit wr, input bit done, input bit tmo);
        outs_t e = base();
        e.i_or_d = 1'b1;
        if (tmo) e.bus_error = 1'b1;
        else if (wr) begin e.mem_write = 1'b1; e.retire = done; end
        else e.mem_read = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_wb_lw();
        outs_t e = base();
        e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.retire = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_branch(input bit ne);
        outs_t e = base();
        e.alu_src_a = 2'b01; e.alu_control = 4'b0010; e.pc_write_cond = 1'b1;
        e.pc_source = 2'b01; e.branch_ne = ne; e.retire = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_jump(input bit jal);
        outs_t e = base();
        e.pc_write = 1'b1; e.pc_source = 2'b10; e.retire = 1'b1;
        if (jal) begin e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
        return e;
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic logic coin();
        return 1'($urandom);
    endfunction

    // ---------------- checking and stepping ----------------
    task automatic check(input string tag, input outs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs at the falling edge, then move
    // to just after the next rising edge.
    task automatic step(input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                        input outs_t exp, input string tag);
        mem_ready = rdy; opcode = op; funct = fn;
        @(negedge clk);
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input bit wr, input int mwait);
        int n = (mwait > MEM_TIMEOUT) ? MEM_TIMEOUT : mwait;
        for (int i = 0; i < n; i++) step(1'b0, junk(), junk(), o_mem(wr, 1'b0, 1'b0), "mem_wait");
        if (mwait > MEM_TIMEOUT) begin
            step(1'b0, junk(), junk(), o_mem(wr, 1'b0, 1'b1), "mem_timeout");
        end else begin
            step(1'b1, junk(), junk(), o_mem(wr, 1'b1, 1'b0), "mem_done");
            if (!wr) step(coin(), junk(), junk(), o_wb_lw(), "wb_lw");
        end
    endtask

    // One instruction from FETCH to its return to FETCH. mwait > MEM_TIMEOUT
    // means memory never answers and the access must time out.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fwait, input int mwait);
        ent_t inf = classify(op, fn);
        for (int i = 0; i < fwait; i++) step(1'b0, junk(), junk(), o_fetch(1'b0), "fetch_wait");
        step(1'b1, junk(), junk(), o_fetch(1'b1), "fetch_done");
        step(coin(), op, fn, o_decode(inf.kind), "decode");
        case (inf.kind)
            K_R, K_I: begin
                step(coin(), junk(), junk(), o_exec(inf), "exec");
                step(coin(), junk(), junk(), o_wb_alu(inf.kind == K_R), "wb_alu");
            end
            K_LW, K_SW: begin
                step(coin(), junk(), junk(), o_mem_addr(), "mem_addr");
                mem_phase(inf.kind == K_SW, mwait);
            end
            K_BEQ, K_BNE: step(coin(), junk(), junk(), o_branch(inf.kind == K_BNE), "branch");
            K_J, K_JAL:   step(coin(), junk(), junk(), o_jump(inf.kind == K_JAL), "jump");
            default: ;
        endcase
    endtask

    task automatic fetch_timeout();
        for (int i = 0; i < MEM_TIMEOUT; i++) step(1'b0, junk(), junk(), o_fetch(1'b0), "fetch_wait");
        step(1'b0, junk(), junk(), o_fetch_tmo(), "fetch_timeout");
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        load_isa();
        rst = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
        #12;
        check("reset_outputs", '0);
        mem_ready = 1'b1; opcode = 6'o43;
        #1;
        check("reset_outputs_ready", '0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(6'o00, 6'o40, 0, 0);            // ADD, 4 cycles
        run_instr(6'o43, junk(), 0, 3);           // LW, 3 stalls in MEM_RD, 8 cycles
        run_instr(6'o53, junk(), 1, 2);           // SW with stalls
        run_instr(6'o05, junk(), 0, 0);           // BNE
        run_instr(6'o04, junk(), 0, 0);           // BEQ
        run_instr(6'o03, junk(), 0, 0);           // JAL
        run_instr(6'o02, junk(), 0, 0);           // J
        run_instr(6'o66, junk(), 0, 0);           // NOP, 2 cycles
        run_instr(6'o77, junk(), 0, 0);           // unknown opcode
        run_instr(6'o00, 6'o77, 0, 0);            // R-type with unknown funct
        run_instr(6'o00, 6'o00, 0, 0);            // SLL uses shamt
        run_instr(6'o15, junk(), 0, 0);           // ORI zero-extends

        fetch_timeout();                          // bus_error at cycle MEM_TIMEOUT+1
        run_instr(6'o00, 6'o42, MEM_TIMEOUT, 0);  // ready on the limit cycle wins
        run_instr(6'o43, junk(), 0, MEM_TIMEOUT); // same for MEM_RD
        run_instr(6'o43, junk(), 0, MEM_TIMEOUT + 1);
        run_instr(6'o53, junk(), 0, MEM_TIMEOUT + 1);
        run_instr(6'o00, 6'o41, 0, 0);

        for (int n = 0; n < 60; n++) begin
            ent_t e = isa[$urandom_range(isa.size() - 1, 0)];
            logic [5:0] op = e.op;
            logic [5:0] fn = (e.op == 6'o00) ? e.fn : junk();
            if ($urandom_range(9, 0) == 0) begin op = junk(); fn = junk(); end
            run_instr(op, fn, $urandom_range(3, 0), $urandom_range(3, 0));
        end

        // Reset while a store is waiting in MEM_WR.
        step(1'b1, junk(), junk(), o_fetch(1'b1), "rw_fetch");
        step(coin(), 6'o53, junk(), o_decode(K_SW), "rw_decode");
        step(coin(), junk(), junk(), o_mem_addr(), "rw_mem_addr");
        step(1'b0, junk(), junk(), o_mem(1'b1, 1'b0, 1'b0), "rw_mem_wr");
        mem_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_in_mem_wr", '0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("rst_held", '0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(6'o00, 6'o44, 0, 0);            // restarts cleanly from FETCH
        run_instr(6'o53, junk(), 0, 0);           // SW, 4 cycles

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle_control.md
Name: cpu_multicycle_control

Overview:
Multicycle control FSM for the MIPS-subset CPU. It replaces the single-cycle combinational control unit. The block sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, stalls on a memory ready handshake, and times out hung memory accesses. It drives datapath muxes, register-file and memory strobes, and ALU control. It sits between the instruction register and the shared datapath.

Parameters:
ALU_CTRL_W, 4, ALU control width. Values are right-aligned; upper bits are zero.
MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before bus_error. Must be at least 1.
TMO_W, 4, timeout counter width. Must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]; valid from DECODE onward
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes the current read or write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch taken
branch_ne  out  1  1 = take on !zero (BNE); 0 = take on zero (BEQ)
pc_source  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  2  00 rt, 01 rd, 10 r31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
reg_write  out  1  register-file write
alu_src_a  out  2  00 PC, 01 A, 10 shamt
alu_src_b  out  2  00 B, 01 constant 4, 10 extended imm, 11 sign-ext imm<<2
ext_zero  out  1  1 = zero-extend immediate (ANDI, ORI, XORI)
alu_control  out  ALU_CTRL_W  ALU operation
retire  out  1  one-cycle pulse when an instruction completes
illegal  out  1  one-cycle pulse in DECODE for an unknown opcode or funct
bus_error  out  1  one-cycle pulse on memory timeout

Behaviour:
- State register: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WR, WB_LW, BRANCH, JUMP. Async reset to FETCH.
- Outputs are combinational from state, mem_ready and latched opcode/funct. While rst=1 every output is forced to 0.
- Latching: opcode/funct are captured on exit from DECODE and held until the next DECODE.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, ADDU, pc_source=00.
  - When mem_ready=1 in that cycle, also drives ir_write=1 and pc_write=1, and moves to DECODE. Otherwise stays in FETCH.
- DECODE:
  - Computes the branch target: alu_src_a=00, alu_src_b=11, ADD.
  - Dispatch:
    - R-type → EXEC_R.
    - ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU → EXEC_I.
    - LW, SW → MEM_ADDR.
    - BEQ, BNE → BRANCH.
    - J, JAL → JUMP.
    - NOP (110110) → FETCH with retire=1.
    - Unknown opcode, or R-type with unknown funct → FETCH with illegal=1 and no retire.
- EXEC_R:
  - alu_src_a=10 for SLL, SRA, SRL; otherwise 01. alu_src_b=00. Next state WB_ALU.
- EXEC_I:
  - alu_src_a=01, alu_src_b=10, ext_zero per opcode. Next state WB_ALU.
- WB_ALU:
  - reg_write=1, mem_to_reg=00, retire=1, then FETCH.
  - reg_dst=01 for R-type, 00 for I-type.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, ADDU. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD / MEM_WR:
  - i_or_d=1; mem_read (MEM_RD) or mem_write (MEM_WR) held until mem_ready.
  - On mem_ready, MEM_RD → WB_LW; MEM_WR → FETCH with retire=1.
- WB_LW: reg_write=1, reg_dst=00, mem_to_reg=01, retire=1, then FETCH.
- BRANCH:
  - alu_src_a=01, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01.
  - branch_ne=1 for BNE. retire=1, then FETCH.
- JUMP:
  - pc_write=1, pc_source=10, retire=1, then FETCH.
  - For JAL also reg_write=1, reg_dst=10, mem_to_reg=10.
  - PC already holds PC+4 at this point, so r31 receives PC+4.
- ALU codes:
  - ADD/ADDI 0111, ADDU/ADDIU 0001, SUB 0010, SUBU 0011, AND/ANDI 0100, OR/ORI 0101, XOR/XORI 0110.
  - SLL 1110, SRA 1100, SRL 1101, SLT/SLTI 1010, SLTU/SLTIU 1011.
  - States not listed above drive 0001.
- Timeout:
  - The counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle that state waits with mem_ready=0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: bus_error=1, strobes drop, next state FETCH, no retire, PC unchanged.
  - mem_ready=1 in the same cycle as the limit wins: normal completion.
- Latency with mem_ready tied to 1:
  - R-type and I-type ALU: 4 cycles. LW: 5. SW: 4. Branch, J, JAL: 3. NOP: 2.
- Reset mid-instruction: immediate return to FETCH with all outputs 0; no partial writes occur after the reset edge.

Decomposition:
- Shared package cpu_isa_pkg holds the opcode and funct constants, the ALU control code constants, and the state encoding.
- Sub-module cpu_alu_decode: purely combinational (latched opcode, funct, state) → alu_control, ext_zero, legal flag.

Test Plan:
- ADD with mem_ready=1 → FETCH, DECODE, EXEC_R, WB_ALU. alu_control 0111 in EXEC_R; reg_write=1, reg_dst=01 in WB_ALU; retire in cycle 4.
- LW with mem_ready low 3 cycles in MEM_RD → mem_read held 4 cycles, then WB_LW with mem_to_reg=01, reg_write=1; total 8 cycles.
- SW → mem_write=1 and reg_write=0 throughout; retire on the mem_ready cycle.
- BNE → BRANCH with alu_control 0010, pc_write_cond=1, branch_ne=1, pc_source=01.
- JAL → JUMP with pc_write=1, pc_source=10, reg_dst=10, mem_to_reg=10, reg_write=1.
- Edge cases:
  - Opcode 111111 → illegal pulse, back to FETCH after 2 cycles, no retire.
  - mem_ready held 0 in FETCH → bus_error exactly at cycle MEM_TIMEOUT+1, then FETCH restarts.
  - rst asserted in MEM_WR → mem_write drops at once and state is FETCH.
